uart_rx_packet_parser: RTL and testbench
========================================

Name: uart_rx_packet_parser

Overview:
Sits directly downstream of the UART byte receiver. It consumes the receiver's one-cycle byte-done pulses and assembles framed packets into 16-bit little-endian words. Words go to the softmax datapath through a small valid/ready FIFO. Framing, checksum, length and inter-byte timeout errors are reported per frame.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker byte
MAX_LEN, 64, maximum words per frame (legal range 1..255)
FIFO_DEPTH, 8, output word FIFO depth (power of 2, at least 2)
TIMEOUT_CYC, 50000, idle clock cycles allowed between bytes inside a frame

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous active-high reset
i_rx_done  input  1  one-cycle pulse: i_rxd holds a new byte
i_rxd  input  8  received byte
o_word_valid  output  1  FIFO head word available
o_word  output  16  FIFO head word, {hi,lo}
o_word_last  output  1  head word is the final word of its frame
i_word_ready  input  1  consumer accepts the head word this cycle
o_frame_done  output  1  one-cycle pulse at end of frame (good or bad)
o_frame_err  output  1  qualifies o_frame_done: frame bad
o_err_code  output  3  0 OK, 1 CHK, 2 LEN, 3 TIMEOUT, 4 OVF (valid with o_frame_done)
o_overflow  output  1  sticky: a word was dropped because the FIFO was full
o_busy  output  1  parser state is not IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state IDLE, FIFO empty, all outputs 0. Reset mid-frame discards the partial frame and all FIFO contents; no o_frame_done is issued.
- Frame format: SOF, LEN (word count), 2*LEN payload bytes (lo then hi per word), CHK.
  - CHK = XOR of LEN and all payload bytes.
- Bytes are sampled only in a cycle where i_rx_done=1. State updates at that clock edge.
- States and transitions:
  - IDLE: byte == SOF_BYTE goes to LEN. Any other byte is discarded silently; no error is raised.
  - LEN: if LEN==0 or LEN>MAX_LEN, pulse done with err code 2 and return to IDLE. Otherwise latch LEN, clear the word index, seed the checksum accumulator with LEN, clear the frame-overflow flag, and go to DATA_LO.
  - DATA_LO: latch the low byte, XOR it into the checksum, go to DATA_HI.
  - DATA_HI: push the word {byte,lo} into the FIFO with last = (index == LEN-1). XOR the byte into the checksum. Increment the index. Go to CHK if this was the last word, else DATA_LO.
  - CHK: pulse done and return to IDLE. Error code priority: OVF (4) if the frame-overflow flag is set; else CHK (1) if the byte does not match the accumulator; else OK.
- o_frame_done, o_frame_err and o_err_code are registered. They are valid the cycle after the terminating byte's edge, are high for exactly 1 cycle, and o_err_code returns to 0 afterwards.
- Timeout:
  - The counter clears on every accepted byte and on entry to any non-IDLE state.
  - It counts every cycle while in a non-IDLE state with no byte arriving.
  - On reaching TIMEOUT_CYC, pulse done with err code 3 and return to IDLE.
  - A byte arriving in the same cycle the counter would hit the limit wins; no timeout fires.
  - The counter is sized to ceil(log2(TIMEOUT_CYC+1)) bits.
- FIFO:
  - First-word-fall-through. o_word_valid rises 1 cycle after a push into an empty FIFO.
  - A pop occurs when o_word_valid && i_word_ready.
  - Push while full with no pop in the same cycle: the word is dropped, o_overflow is set (sticky until reset), and the frame-overflow flag is set.
  - Push while full with a pop in the same cycle: the push is accepted.
  - Occupancy counter ranges 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Words already pushed remain in the FIFO when the frame later fails; the consumer uses o_frame_err to discard them.
- Throughput: the parser never stalls byte intake (the receiver has no backpressure).

Test Plan:
- Good frame: A5 02 34 12 78 56 0A, i_word_ready=1 -> o_word 0x1234 (last=0) then 0x5678 (last=1); o_frame_done=1, o_frame_err=0, code 0.
- Bad checksum: the same frame with CHK=0x0B -> both words still output; done with err=1, code 1.
- Bad length: A5 00, then separately A5 41 with MAX_LEN=64 -> each gives done, err=1, code 2, parser back in IDLE; the next valid frame parses correctly.
- Timeout with TIMEOUT_CYC=100: A5 02 34 then silence -> done, code 3, exactly 100 cycles after the byte 0x34; o_busy drops. A following byte 0x12 is ignored.
- Overflow with FIFO_DEPTH=8, LEN=10, i_word_ready=0 -> 8 words held, o_overflow=1, done code 4. Then with ready=1, words 1..8 drain in order.
- Junk and reset: 00 FF A5 01 CD AB 67 -> word 0xABCD last=1, code 0. Then assert i_rst mid-frame after A5 01 CD -> FIFO empty, all outputs 0, no done pulse.

Source files
------------

// File: rtl/uart_rx_packet_parser.sv
// Word FIFO: first-word-fall-through, head valid the cycle after a push into empty.
// No internal drop logic; the caller only pushes while full when it also pops.
module uart_rx_word_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_dat,
   output logic             o_head_vld,
   output logic             o_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   assign o_head_vld = (count != '0);
   assign o_full     = (count == DEPTH_C);
   assign o_head_dat = mem[rd_ptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) wr_ptr <= wr_ptr + 1'b1;
         if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (i_push && !i_pop)      count <= count + 1'b1;
         else if (!i_push && i_pop) count <= count - 1'b1;
      end
   end

   // Full + pop + push overwrites the slot being popped this same cycle.
   always_ff @(posedge i_clk) begin
      if (i_push) mem[wr_ptr] <= i_push_dat;
   end
endmodule

// Assembles SOF/LEN/payload/CHK frames into 16-bit words; result pulse 1 cycle after last byte.
// Byte intake never stalls; words are dropped (and flagged) when the FIFO is full.
module uart_rx_packet_parser #(
   parameter logic [7:0] SOF_BYTE    = 8'hA5,
   parameter int         MAX_LEN     = 64,
   parameter int         FIFO_DEPTH  = 8,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rx_done,
   input  logic [7:0]  i_rxd,
   output logic        o_word_valid,
   output logic [15:0] o_word,
   output logic        o_word_last,
   input  logic        i_word_ready,
   output logic        o_frame_done,
   output logic        o_frame_err,
   output logic [2:0]  o_err_code,
   output logic        o_overflow,
   output logic        o_busy
);
   localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [2:0] ERR_OK = 3'd0, ERR_CHK = 3'd1, ERR_LEN = 3'd2,
                          ERR_TIMEOUT = 3'd3, ERR_OVF = 3'd4;

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA_LO, S_DATA_HI, S_CHK} state_t;

   state_t        state, state_nxt;
   logic [7:0]    len, len_nxt, idx, idx_nxt, chk, chk_nxt, lo, lo_nxt;
   logic [TW-1:0] to_cnt, to_cnt_nxt;
   logic          frame_ovf, frame_ovf_nxt;
   logic          done_nxt;
   logic [2:0]    code_nxt;
   logic          push, push_ok, pop, fifo_full, head_vld;
   logic [16:0]   push_dat, head_dat;

   assign pop     = head_vld && i_word_ready;
   assign push_ok = push && (!fifo_full || pop);

   uart_rx_word_fifo #(.WIDTH(17), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (push_ok),
      .i_push_dat (push_dat),
      .i_pop      (pop),
      .o_head_dat (head_dat),
      .o_head_vld (head_vld),
      .o_full     (fifo_full)
   );

   assign o_word_valid = head_vld;
   assign o_word       = head_vld ? head_dat[15:0] : 16'h0000;
   assign o_word_last  = head_vld & head_dat[16];
   assign o_busy       = (state != S_IDLE);

   always_comb begin
      state_nxt     = state;
      len_nxt       = len;
      idx_nxt       = idx;
      chk_nxt       = chk;
      lo_nxt        = lo;
      frame_ovf_nxt = frame_ovf;
      done_nxt      = 1'b0;
      code_nxt      = ERR_OK;
      push          = 1'b0;
      push_dat      = {(idx == len - 8'd1), i_rxd, lo};
      to_cnt_nxt    = (state == S_IDLE || i_rx_done) ? '0 : to_cnt + 1'b1;

      case (state)
         S_IDLE: begin
            if (i_rx_done && i_rxd == SOF_BYTE) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (i_rx_done) begin
               if (i_rxd == 8'd0 || i_rxd > MAX_LEN_B) begin
                  done_nxt  = 1'b1;
                  code_nxt  = ERR_LEN;
                  state_nxt = S_IDLE;
               end else begin
                  len_nxt       = i_rxd;
                  idx_nxt       = 8'd0;
                  chk_nxt       = i_rxd;
                  frame_ovf_nxt = 1'b0;
                  state_nxt     = S_DATA_LO;
               end
            end
         end
         S_DATA_LO: begin
            if (i_rx_done) begin
               lo_nxt    = i_rxd;
               chk_nxt   = chk ^ i_rxd;
               state_nxt = S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (i_rx_done) begin
               push      = 1'b1;
               chk_nxt   = chk ^ i_rxd;
               idx_nxt   = idx + 8'd1;
               state_nxt = push_dat[16] ? S_CHK : S_DATA_LO;
               if (fifo_full && !pop) frame_ovf_nxt = 1'b1;
            end
         end
         S_CHK: begin
            if (i_rx_done) begin
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
               if (frame_ovf)        code_nxt = ERR_OVF;
               else if (i_rxd != chk) code_nxt = ERR_CHK;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // A byte landing on the limit cycle is accepted instead of timing out.
      if (state != S_IDLE && !i_rx_done && to_cnt == TO_LAST) begin
         done_nxt   = 1'b1;
         code_nxt   = ERR_TIMEOUT;
         state_nxt  = S_IDLE;
         to_cnt_nxt = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         len          <= '0;
         idx          <= '0;
         chk          <= '0;
         lo           <= '0;
         to_cnt       <= '0;
         frame_ovf    <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         o_err_code   <= ERR_OK;
         o_overflow   <= 1'b0;
      end else begin
         state        <= state_nxt;
         len          <= len_nxt;
         idx          <= idx_nxt;
         chk          <= chk_nxt;
         lo           <= lo_nxt;
         to_cnt       <= to_cnt_nxt;
         frame_ovf    <= frame_ovf_nxt;
         o_frame_done <= done_nxt;
         o_frame_err  <= done_nxt && (code_nxt != ERR_OK);
         o_err_code   <= code_nxt;
         if (push && !push_ok) o_overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Scoreboard bench: frame-level reference model feeds expected words/results; a negedge monitor compares.
module tb_uart_rx_packet_parser;
   localparam logic [7:0] SOF = 8'hA5;
   localparam int MAX_LEN = 64;
   localparam int DEPTH   = 8;
   localparam int TOUT    = 100;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_rx_done = 1'b0;
   logic [7:0]  i_rxd = 8'h00;
   logic        i_word_ready = 1'b0;
   logic        o_word_valid, o_word_last, o_frame_done, o_frame_err, o_overflow, o_busy;
   logic [15:0] o_word;
   logic [2:0]  o_err_code;

   int n_checks = 0;
   int n_pass   = 0;
   int rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random with backlog guard
   int gap_max  = 0;
   logic [16:0] exp_words[$];
   logic [2:0]  exp_codes[$];
   logic [15:0] frame_words[$];

   uart_rx_packet_parser #(.SOF_BYTE(SOF), .MAX_LEN(MAX_LEN), .FIFO_DEPTH(DEPTH),
                           .TIMEOUT_CYC(TOUT)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rx_done(i_rx_done), .i_rxd(i_rxd),
      .o_word_valid(o_word_valid), .o_word(o_word), .o_word_last(o_word_last),
      .i_word_ready(i_word_ready), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
      .o_err_code(o_err_code), .o_overflow(o_overflow), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_word_valid && i_word_ready) begin
            if (exp_words.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %0h expected none", {o_word_last, o_word});
            end else begin
               check("word", {o_word_last, o_word}, exp_words.pop_front());
            end
         end
         if (o_frame_done) begin
            if (exp_codes.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: got code %0d expected no pulse", o_err_code);
            end else begin
               logic [2:0] ec;
               ec = exp_codes.pop_front();
               check("err_code", o_err_code, ec);
               check("frame_err", o_frame_err, (ec != 3'd0));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         #2;
         case (rdy_mode)
            0: i_word_ready = 1'b0;
            1: i_word_ready = 1'b1;
            default: i_word_ready = (exp_words.size() >= 4) ? 1'b1 : ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge i_clk);
      #1;
      i_rxd = b;
      i_rx_done = 1'b1;
      @(posedge i_clk);
      #1;
      i_rx_done = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(posedge i_clk);
   endtask

   // Frame-level model: words that fit are expected in order; result code from frame rules.
   task automatic send_frame(input int len, input logic [7:0] flip, input int keep);
      logic [7:0] c, lo, hi;
      send_byte(SOF);
      if (len == 0 || len > MAX_LEN) begin
         exp_codes.push_back(3'd2);
         send_byte(8'(len));
      end else begin
         send_byte(8'(len));
         c = 8'(len);
         for (int i = 0; i < len; i++) begin
            lo = frame_words[i][7:0];
            hi = frame_words[i][15:8];
            send_byte(lo);
            if (i < keep) exp_words.push_back({(i == len - 1), hi, lo});
            send_byte(hi);
            c = c ^ lo ^ hi;
         end
         exp_codes.push_back(len > keep ? 3'd4 : (flip != 8'd0 ? 3'd1 : 3'd0));
         send_byte(c ^ flip);
      end
   endtask

   task automatic check_all_zero(input string name);
      check(name, {o_word_valid, o_word, o_word_last, o_frame_done, o_frame_err,
                   o_err_code, o_overflow, o_busy}, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      exp_words.delete();
      exp_codes.delete();
      repeat (2) @(posedge i_clk);
      #1;
      check_all_zero("in_reset");
      #2;
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
      check_all_zero("after_reset");
   endtask

   task automatic wait_idle(input int cycles);
      repeat (cycles) @(posedge i_clk);
      #1;
   endtask

   initial begin
      int lat;
      repeat (3) @(posedge i_clk);
      #1;
      check_all_zero("reset_state");
      i_rst = 1'b0;

      // Good frame A5 02 34 12 78 56 0A
      frame_words = '{16'h1234, 16'h5678};
      send_frame(2, 8'h00, 1000);
      wait_idle(4);
      check("busy_after_good", o_busy, 1'b0);

      // Same frame, CHK 0x0B
      send_frame(2, 8'h01, 1000);
      wait_idle(4);

      // Bad lengths 0 and 65, each followed by a good frame
      send_frame(0, 8'h00, 1000);
      check("busy_len0", o_busy, 1'b0);
      send_frame(65, 8'h00, 1000);
      check("busy_len65", o_busy, 1'b0);
      frame_words = '{16'hBEEF};
      send_frame(1, 8'h00, 1000);
      wait_idle(4);

      // Timeout: A5 02 34 then silence
      send_byte(SOF);
      send_byte(8'h02);
      send_byte(8'h34);
      exp_codes.push_back(3'd3);
      lat = -1;
      for (int k = 1; k <= 2 * TOUT && lat < 0; k++) begin
         @(posedge i_clk);
         #1;
         if (o_frame_done) lat = k;
      end
      check("timeout_latency", lat, TOUT);
      check("busy_after_timeout", o_busy, 1'b0);
      send_byte(8'h12);
      wait_idle(5);
      check("busy_ignored_byte", o_busy, 1'b0);

      // Overflow: LEN=10 with consumer stalled, then drain
      rdy_mode = 0;
      wait_idle(2);
      frame_words.delete();
      for (int i = 1; i <= 10; i++) frame_words.push_back(16'(i * 257));
      send_frame(10, 8'h00, DEPTH);
      wait_idle(2);
      check("overflow_sticky", o_overflow, 1'b1);
      check("held_valid", o_word_valid, 1'b1);
      rdy_mode = 1;
      wait_idle(20);
      check("drain_empty", exp_words.size(), 0);
      check("overflow_still", o_overflow, 1'b1);

      // Junk then A5 01 CD AB 67
      send_byte(8'h00);
      send_byte(8'hFF);
      check("junk_idle", o_busy, 1'b0);
      frame_words = '{16'hABCD};
      send_frame(1, 8'h00, 1000);
      wait_idle(4);

      // Reset mid-frame with a word parked in the FIFO
      rdy_mode = 0;
      wait_idle(2);
      frame_words = '{16'h4321};
      send_frame(1, 8'h00, 1000);
      send_byte(SOF);
      send_byte(8'h01);
      send_byte(8'hCD);
      do_reset();
      rdy_mode = 1;
      wait_idle(TOUT + 20);
      check("post_reset_valid", o_word_valid, 1'b0);

      // Randomized frames
      rdy_mode = 2;
      gap_max  = 3;
      for (int f = 0; f < 40; f++) begin
         int len;
         logic [7:0] flip, junk;
         repeat ($urandom_range(0, 2)) begin
            junk = 8'($urandom);
            if (junk == SOF) junk = 8'h00;
            send_byte(junk);
         end
         case ($urandom_range(0, 9))
            0: len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
            1: len = MAX_LEN;
            2: len = MAX_LEN + 1;
            default: len = $urandom_range(1, 12);
         endcase
         frame_words.delete();
         for (int i = 0; i < len; i++) frame_words.push_back(16'($urandom));
         flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         send_frame(len, flip, 1000);
      end
      rdy_mode = 1;
      wait_idle(50);
      check("final_words_drained", exp_words.size(), 0);
      check("final_results_seen", exp_codes.size(), 0);
      check("final_overflow", o_overflow, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
